counter_rr_arbiter: RTL

//  Shares one WIDTH-bit up/down counter between NUM_REQ requesters.
//  - Each requester asks for +1 or -1; a round-robin arbiter grants one op per cycle.
//  - Intended as a shared credit, occupancy or event tally fed by several independent agents.
//  - Adds a synchronous clear that has priority over all requests.

---
 rtl/counter_arb_pkg.sv | 16 +
 rtl/rr_arbiter_core.sv | 44 ++++
 rtl/counter_rr_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/counter_arb_pkg.sv
// Shared definitions for the round-robin arbitrated up/down counter:
// index-width helper and the up_down direction encoding.
package counter_arb_pkg;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Direction requested by a port: 0 = decrement, 1 = increment.
  typedef enum logic {
    DEC = 1'b0,
    INC = 1'b1
  } op_t;

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin arbiter. The search starts one past the
// previously granted index and ascends with wrap; the first active request
// wins. With en low nothing is granted.
module rr_arbiter_core
  import counter_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]             req,
  input  logic [idx_width(NUM_REQ)-1:0]  last_id,
  input  logic                           en,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [idx_width(NUM_REQ)-1:0]  gnt_id,
  output logic                           gnt_vld
);

  localparam int IW = idx_width(NUM_REQ);

  logic [IW-1:0] w_idx;
  logic          w_found;

  // Walk the NUM_REQ candidates in priority order and latch onto the first hit.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (int'(last_id) + k >= NUM_REQ) begin
        w_idx = IW'(int'(last_id) + k - NUM_REQ);
      end else begin
        w_idx = IW'(int'(last_id) + k);
      end
      if (en && !w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_id     = w_idx;
        gnt_vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_rr_arbiter.sv
// One WIDTH-bit up/down counter shared by NUM_REQ requesters through a
// round-robin arbiter; one +1/-1 op commits per cycle, clr has priority.
// Optional feature: define COUNTER_ARB_SAT_EN to saturate at 0 / all-ones
// (the op is still acked) and pulse sat_hit; otherwise the counter wraps.
module counter_rr_arbiter
  import counter_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clr,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             up_down,
  output logic [NUM_REQ-1:0]             ack,
  output logic [WIDTH-1:0]               count,
  output logic [idx_width(NUM_REQ)-1:0]  last_id,
  output logic                           at_zero,
  output logic                           at_max,
  output logic                           sat_hit
);

  localparam int IW = idx_width(NUM_REQ);

  logic [WIDTH-1:0]   r_count;
  logic [IW-1:0]      r_last_id;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_gnt_id;
  logic               w_gnt_vld;
  logic               w_arb_en;
  op_t                w_dir;
  logic [WIDTH-1:0]   w_count_next;

  // Reset and clr both suppress any grant in the current cycle.
  assign w_arb_en = !reset && !clr;

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req),
    .last_id (r_last_id),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_id  (w_gnt_id),
    .gnt_vld (w_gnt_vld)
  );

  // Direction of the winning port only; other ports' up_down are ignored.
  assign w_dir = op_t'(|(up_down & w_gnt));

`ifdef COUNTER_ARB_SAT_EN
  logic w_at_limit;
  logic r_sat_hit;

  assign w_at_limit = ((w_dir == INC) && (&r_count)) ||
                      ((w_dir == DEC) && (r_count == '0));

  // Hold the count at the rail instead of wrapping.
  always_comb begin
    w_count_next = r_count;
    if (!w_at_limit) begin
      w_count_next = (w_dir == INC) ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
    end
  end

  // One-cycle pulse after an acked op that hit a rail.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat_hit <= 1'b0;
    end else begin
      r_sat_hit <= w_gnt_vld && w_at_limit;
    end
  end

  assign sat_hit = r_sat_hit;
`else
  // Plain modulo 2^WIDTH arithmetic.
  always_comb begin
    w_count_next = (w_dir == INC) ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
  end

  assign sat_hit = 1'b0;
`endif

  // Counter and pointer: reset beats clr, clr beats a grant; the pointer only moves on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_last_id <= IW'(NUM_REQ - 1);
    end else if (clr) begin
      r_count   <= '0;
    end else if (w_gnt_vld) begin
      r_count   <= w_count_next;
      r_last_id <= w_gnt_id;
    end
  end

  assign ack     = w_gnt;
  assign count   = r_count;
  assign last_id = r_last_id;
  assign at_zero = (r_count == '0);
  assign at_max  = &r_count;

endmodule
